// File: rtl/ram_sweep_clear_if.sv
// Access bus of the sweep-cleared RAM: request side (clear/load/address/in)
// and status/read side (out/out_valid/busy).
interface ram_sweep_clear_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 14
);
    logic              clear;
    logic              load;
    logic [ADDR_W-1:0] address;
    logic [WIDTH-1:0]  in;
    logic [WIDTH-1:0]  out;
    logic              out_valid;
    logic              busy;

    modport master (
        output clear,
        output load,
        output address,
        output in,
        input  out,
        input  out_valid,
        input  busy
    );

    modport slave (
        input  clear,
        input  load,
        input  address,
        input  in,
        output out,
        output out_valid,
        output busy
    );
endinterface

// File: rtl/ram_sweep_clear.sv
// Single-port synchronous RAM whose contents are defined by a hardware clear
// sweep after reset or on request; busy/out_valid let the host stall meanwhile.
module ram_sweep_clear #(
    parameter int               WIDTH     = 16,
    parameter int               ADDR_W    = 14,
    parameter logic [WIDTH-1:0] INIT_VAL  = {WIDTH{1'b0}},
    parameter int               READ_MODE = 32'sd0
) (
    input logic                clk,
    input logic                reset,
    ram_sweep_clear_if.slave   bus
);
    localparam int               DEPTH       = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};
    localparam logic             WRITE_FIRST = (READ_MODE != 32'sd0);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t            state_q,      state_d;
    logic [ADDR_W-1:0] sweep_addr_q, sweep_addr_d;
    logic [WIDTH-1:0]  out_q,        out_d;
    logic              out_valid_q,  out_valid_d;
    logic              busy_q,       busy_d;

    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              we_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [WIDTH-1:0]  wr_data_s;
    logic [WIDTH-1:0]  rd_data_s;

    assign rd_data_s = mem_q[bus.address];
    // Reset outranks everything: no word is written while reset is held.
    assign wr_en_s   = we_s & ~reset;

    // Next-state, shared write-port mux and read-data selection.
    always_comb begin
        state_d      = state_q;
        sweep_addr_d = sweep_addr_q;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        busy_d       = busy_q;
        we_s         = 1'b0;
        wr_addr_s    = bus.address;
        wr_data_s    = bus.in;

        case (state_q)
            ST_CLEAR: begin
                out_d       = {WIDTH{1'b0}};
                out_valid_d = 1'b0;
                if (bus.clear) begin
                    sweep_addr_d = {ADDR_W{1'b0}};
                    busy_d       = 1'b1;
                end else begin
                    we_s      = 1'b1;
                    wr_addr_s = sweep_addr_q;
                    wr_data_s = INIT_VAL;
                    if (sweep_addr_q == LAST_ADDR) begin
                        // Single pass only: park the pointer instead of wrapping.
                        state_d      = ST_IDLE;
                        sweep_addr_d = {ADDR_W{1'b0}};
                        busy_d       = 1'b0;
                    end else begin
                        sweep_addr_d = sweep_addr_q + ADDR_W'(1'b1);
                        busy_d       = 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (bus.clear) begin
                    state_d      = ST_CLEAR;
                    sweep_addr_d = {ADDR_W{1'b0}};
                    busy_d       = 1'b1;
                    out_d        = {WIDTH{1'b0}};
                    out_valid_d  = 1'b0;
                end else begin
                    we_s        = bus.load;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                    if (WRITE_FIRST && bus.load) begin
                        out_d = bus.in;
                    end else begin
                        out_d = rd_data_s;
                    end
                end
            end
            default: begin
                state_d      = ST_CLEAR;
                sweep_addr_d = {ADDR_W{1'b0}};
                busy_d       = 1'b1;
                out_d        = {WIDTH{1'b0}};
                out_valid_d  = 1'b0;
            end
        endcase
    end

    // Control and output registers with synchronous reset into a fresh sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            sweep_addr_q <= {ADDR_W{1'b0}};
            out_q        <= {WIDTH{1'b0}};
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            sweep_addr_q <= sweep_addr_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
        end
    end

    // Storage array: one write port, no reset, so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= wr_data_s;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
endmodule
